nios_system_pio_arbiter: RTL and testbench

- Shares the write port of the 8-bit output PIO register (address 0, low byte of a 32-bit write word) between several hardware requesters, e.g. the reaction timer and the pattern generator.
- Grants one requester at a time and issues a single Avalon-style write to the PIO.
- Enforces a minimum display hold time before the next grant, so every value stays on `out_port` long enough to be seen.
- Sits between the requesters and the PIO slave port; the CPU path is muxed outside this block.

---
 rtl/nios_system_pio_arbiter.sv | 148 ++++++++++++++
 tb/tb_nios_system_pio_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_pio_arbiter.sv
// Arbitrates hardware requesters onto the 8-bit output PIO write port, one write per grant, with a display hold time.
// Optional build macro PIO_ARB_FIXED_PRIO_EN selects fixed lowest-index-wins priority instead of round-robin.
module nios_system_pio_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      pio_chipselect,
    output logic                      pio_write_n,
    output logic [1:0]                pio_address,
    output logic [31:0]               pio_writedata,
    output logic                      busy,
    output logic [2:0]                last_owner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [15:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 16'(HOLD_CYCLES - 1) : 16'd0;
    localparam logic [2:0]  LAST_IDX  = 3'(NUM_REQ - 1);

    state_t             r_state;
    logic [15:0]        r_count;
    logic [2:0]         r_winner;
    logic [2:0]         w_winner;
    logic               w_found;
    logic [NUM_REQ-1:0] w_onehot;
    logic [31:0]        w_payload;

    assign pio_address = 2'b00;

`ifdef PIO_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest asserted index wins.
    always_comb begin
        w_winner = 3'd0;
        w_found  = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_winner = (!w_found && req[j]) ? 3'(j) : w_winner;
            w_found  = w_found | req[j];
        end
    end
`else
    logic [2:0] r_ptr;

    // Round-robin: first pass scans from the pointer upward, second pass wraps to the indices below it.
    always_comb begin
        w_winner = 3'd0;
        w_found  = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_winner = (!w_found && req[j] && (3'(j) >= r_ptr)) ? 3'(j) : w_winner;
            w_found  = w_found | (req[j] && (3'(j) >= r_ptr));
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            w_winner = (!w_found && req[j] && (3'(j) < r_ptr)) ? 3'(j) : w_winner;
            w_found  = w_found | (req[j] && (3'(j) < r_ptr));
        end
    end
`endif

    // Grant vector and zero-extended payload of the selected requester.
    always_comb begin
        w_onehot  = '0;
        w_payload = 32'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_onehot[j] = (w_winner == 3'(j));
            w_payload[DATA_W-1:0] = (w_winner == 3'(j)) ? req_data[j*DATA_W +: DATA_W]
                                                         : w_payload[DATA_W-1:0];
        end
    end

    // Control FSM; all PIO-facing outputs are registered so the write cycle is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_count        <= 16'd0;
            r_winner       <= 3'd0;
            gnt            <= '0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= 32'd0;
            busy           <= 1'b0;
            last_owner     <= 3'd0;
`ifndef PIO_ARB_FIXED_PRIO_EN
            r_ptr          <= 3'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state        <= S_WRITE;
                        r_winner       <= w_winner;
                        gnt            <= w_onehot;
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= 1'b0;
                        pio_writedata  <= w_payload;
                        busy           <= 1'b1;
                    end else begin
                        busy           <= 1'b0;
                    end
                end
                S_WRITE: begin
                    gnt            <= '0;
                    pio_chipselect <= 1'b0;
                    pio_write_n    <= 1'b1;
                    pio_writedata  <= 32'd0;
                    last_owner     <= r_winner;
`ifndef PIO_ARB_FIXED_PRIO_EN
                    r_ptr          <= (r_winner == LAST_IDX) ? 3'd0 : r_winner + 3'd1;
`endif
                    if (HOLD_CYCLES > 0) begin
                        r_state <= S_HOLD;
                        r_count <= HOLD_LOAD;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_HOLD: begin
                    // Requests are not sampled here; a requester that keeps req high is seen again in IDLE.
                    if (r_count == 16'd0) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_count <= r_count - 16'd1;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    gnt            <= '0;
                    pio_chipselect <= 1'b0;
                    pio_write_n    <= 1'b1;
                    pio_writedata  <= 32'd0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_system_pio_arbiter.sv
// Self-checking bench for nios_system_pio_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model (busy window length and modular arbitration search).
module tb_nios_system_pio_arbiter;

    localparam int A_N = 2, A_DW = 8, A_HOLD = 4;
    localparam int B_N = 3, B_DW = 6, B_HOLD = 0;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [A_N-1:0]    a_req = '0;
    logic [A_N*A_DW-1:0] a_data = '0;
    logic [A_N-1:0]    a_gnt;
    logic              a_cs, a_wn, a_busy;
    logic [1:0]        a_addr;
    logic [31:0]       a_wd;
    logic [2:0]        a_last;
    logic [B_N-1:0]    b_req = '0;
    logic [B_N*B_DW-1:0] b_data = '0;
    logic [B_N-1:0]    b_gnt;
    logic              b_cs, b_wn, b_busy;
    logic [1:0]        b_addr;
    logic [31:0]       b_wd;
    logic [2:0]        b_last;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state, index 0 = DUT a, 1 = DUT b
    int          m_hold[2];
    int          m_ptr[2];
    int          m_last[2];
    int          m_win[2];
    bit          m_wr[2];
    logic [31:0] m_wd[2];

    nios_system_pio_arbiter #(.NUM_REQ(A_N), .DATA_W(A_DW), .HOLD_CYCLES(A_HOLD)) u_dut_a (
        .clk(clk), .reset(reset), .req(a_req), .req_data(a_data), .gnt(a_gnt),
        .pio_chipselect(a_cs), .pio_write_n(a_wn), .pio_address(a_addr),
        .pio_writedata(a_wd), .busy(a_busy), .last_owner(a_last));

    nios_system_pio_arbiter #(.NUM_REQ(B_N), .DATA_W(B_DW), .HOLD_CYCLES(B_HOLD)) u_dut_b (
        .clk(clk), .reset(reset), .req(b_req), .req_data(b_data), .gnt(b_gnt),
        .pio_chipselect(b_cs), .pio_write_n(b_wn), .pio_address(b_addr),
        .pio_writedata(b_wd), .busy(b_busy), .last_owner(b_last));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    // One clock of the reference model: a write lasts one cycle, then a busy window of hold cycles.
    task automatic model_step(input int d, input int n, input int hold, input int dw,
                              input logic [7:0] rq, input logic [63:0] pay);
        int w;
        int c;
        if (reset) begin
            m_hold[d] = 0; m_ptr[d] = 0; m_last[d] = 0; m_win[d] = 0; m_wr[d] = 1'b0; m_wd[d] = 32'd0;
        end else if (m_wr[d]) begin
            m_last[d] = m_win[d];
            m_ptr[d]  = (m_win[d] + 1) % n;
            m_wr[d]   = 1'b0;
            m_wd[d]   = 32'd0;
            m_hold[d] = hold;
        end else if (m_hold[d] > 0) begin
            m_hold[d] = m_hold[d] - 1;
        end else begin
            w = -1;
            for (int i = 0; i < n; i++) begin
`ifdef PIO_ARB_FIXED_PRIO_EN
                c = i;
`else
                c = (m_ptr[d] + i) % n;
`endif
                if (w < 0 && rq[c]) w = c;
            end
            if (w >= 0) begin
                m_wr[d]  = 1'b1;
                m_win[d] = w;
                m_wd[d]  = 32'((pay >> (w * dw)) & ((64'd1 << dw) - 64'd1));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, A_N, A_HOLD, A_DW, 8'(a_req), 64'(a_data));
        model_step(1, B_N, B_HOLD, B_DW, 8'(b_req), 64'(b_data));
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; a_req = 2'b11; a_data = {8'h3C, 8'h5A}; b_req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (a_gnt !== 2'b00 || a_wn !== 1'b1 || a_busy !== 1'b0 || a_cs !== 1'b0 || a_wd !== 32'd0 || a_last !== 3'd0) begin
                n_bad++;
                $display("FAIL reset_hold: gnt=%b wn=%b busy=%b cs=%b wd=%h last=%0d, required 00 1 0 0 0 0",
                         a_gnt, a_wn, a_busy, a_cs, a_wd, a_last);
            end
        end
        // The first edge seeing reset low also samples req, so the write is in the following cycle.
        reset = 1'b0;
        tick();
        n_cmp++;
        if (a_gnt !== 2'b01 || a_wd !== 32'h0000005A || a_busy !== 1'b1 || a_wn !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_first_write: gnt=%b wd=%h busy=%b wn=%b, required 01 0000005a 1 0",
                     a_gnt, a_wd, a_busy, a_wn);
        end
        a_req = '0;
    endtask

    task automatic test_single_write();
        int t_first;
        int budget;
        reset = 1'b1; tick(); reset = 1'b0;
        a_req = 2'b01; a_data = {8'($urandom), 8'hA5};
        budget = 10;
        do begin tick(); budget--; end while (a_gnt === 2'b00 && budget > 0);
        n_cmp++;
        if (a_gnt !== 2'b01 || a_wd !== 32'h000000A5 || a_cs !== 1'b1 || a_wn !== 1'b0 || a_addr !== 2'b00) begin
            n_bad++;
            $display("FAIL single_write: gnt=%b wd=%h cs=%b wn=%b addr=%b, required 01 000000a5 1 0 00",
                     a_gnt, a_wd, a_cs, a_wn, a_addr);
        end
        t_first = cyc;
        tick();
        n_cmp++;
        if (a_gnt !== 2'b00 || a_cs !== 1'b0 || a_wn !== 1'b1 || a_wd !== 32'd0 || a_busy !== 1'b1 || a_last !== 3'd0) begin
            n_bad++;
            $display("FAIL after_write: gnt=%b cs=%b wn=%b wd=%h busy=%b last=%0d, required 00 0 1 0 1 0",
                     a_gnt, a_cs, a_wn, a_wd, a_busy, a_last);
        end
        budget = 20;
        do begin tick(); budget--; end while (a_gnt === 2'b00 && budget > 0);
        n_cmp++;
        if (a_gnt !== 2'b01 || (cyc - t_first) != A_HOLD + 2) begin
            n_bad++;
            $display("FAIL repeat_period: gnt=%b gap=%0d, required 01 gap %0d", a_gnt, cyc - t_first, A_HOLD + 2);
        end
        a_req = '0;
        budget = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (a_gnt !== 2'b00) budget++;
        end
        n_cmp++;
        if (budget != 0) begin
            n_bad++;
            $display("FAIL released_no_write: writes=%0d, required 0", budget);
        end
    endtask

    task automatic test_round_robin();
        int got;
        int budget;
        logic [1:0] exp_g;
        reset = 1'b1; tick(); reset = 1'b0;
        a_req = 2'b11; a_data = {8'($urandom), 8'($urandom)};
        got = 0; budget = 60;
        while (got < 4 && budget > 0) begin
            tick(); budget--;
            if (a_gnt !== 2'b00) begin
`ifdef PIO_ARB_FIXED_PRIO_EN
                exp_g = 2'b01;
`else
                exp_g = (got % 2 == 0) ? 2'b01 : 2'b10;
`endif
                n_cmp++;
                if (a_gnt !== exp_g || a_wd !== ((exp_g == 2'b01) ? {24'd0, a_data[7:0]} : {24'd0, a_data[15:8]})) begin
                    n_bad++;
                    $display("FAIL rr_grant%0d: gnt=%b wd=%h, required gnt %b", got, a_gnt, a_wd, exp_g);
                end
                got++;
            end
        end
        n_cmp++;
        if (got != 4) begin
            n_bad++;
            $display("FAIL rr_timeout: grants=%0d, required 4", got);
        end
        a_req = '0;
    endtask

    task automatic test_hold_zero();
        int writes;
        int prev;
        reset = 1'b1; tick(); reset = 1'b0;
        b_req = 3'b100; b_data = 18'($urandom);
        writes = 0; prev = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (b_gnt !== 3'b000) begin
                n_cmp++;
                if (b_gnt !== 3'b100 || b_wd !== {26'd0, b_data[17:12]} || (prev >= 0 && cyc - prev != 2)) begin
                    n_bad++;
                    $display("FAIL hold0_write: gnt=%b wd=%h gap=%0d, required 100 %h gap 2",
                             b_gnt, b_wd, cyc - prev, {26'd0, b_data[17:12]});
                end
                prev = cyc;
                writes++;
            end
        end
        n_cmp++;
        if (writes != 10) begin
            n_bad++;
            $display("FAIL hold0_count: writes=%0d, required 10", writes);
        end
        b_req = '0;
    endtask

    task automatic test_reset_mid();
        int budget;
        reset = 1'b1; tick(); reset = 1'b0;
        a_req = 2'b01; a_data = {8'h77, 8'h11};
        budget = 10;
        do begin tick(); budget--; end while (a_gnt === 2'b00 && budget > 0);
        tick(); tick();
        n_cmp++;
        if (a_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_in_hold: busy=%b, required 1", a_busy);
        end
        reset = 1'b1; tick();
        n_cmp++;
        if (a_busy !== 1'b0 || a_gnt !== 2'b00 || a_cs !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_hold: busy=%b gnt=%b cs=%b, required 0 00 0", a_busy, a_gnt, a_cs);
        end
        // Requester 0 was last served, so only a cleared pointer gives it the grant again.
        reset = 1'b0; a_req = 2'b11;
        tick();
        n_cmp++;
        if (a_gnt !== 2'b01 || a_wd !== 32'h00000011) begin
            n_bad++;
            $display("FAIL mid_after_release: gnt=%b wd=%h, required 01 00000011", a_gnt, a_wd);
        end
        reset = 1'b1; tick();
        n_cmp++;
        if (a_gnt !== 2'b00 || a_cs !== 1'b0 || a_wn !== 1'b1 || a_wd !== 32'd0 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_write: gnt=%b cs=%b wn=%b wd=%h busy=%b, required 00 0 1 0 0",
                     a_gnt, a_cs, a_wn, a_wd, a_busy);
        end
        reset = 1'b0; a_req = '0;
        tick();
    endtask

    task automatic test_withdrawn();
        int budget;
        int bad_cycles;
        reset = 1'b1; tick(); reset = 1'b0;
        a_req = 2'b01; a_data = {8'hC3, 8'h21};
        budget = 10;
        do begin tick(); budget--; end while (a_gnt === 2'b00 && budget > 0);
        a_req = 2'b00; tick();
        a_req = 2'b10; tick();
        a_req = 2'b00;
        bad_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (a_gnt !== 2'b00 || a_wd !== 32'd0) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles != 0) begin
            n_bad++;
            $display("FAIL withdrawn: cycles with write=%0d, required 0", bad_cycles);
        end
    endtask

    task automatic test_random();
        logic [A_N-1:0] exp_ga;
        logic [B_N-1:0] exp_gb;
        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(0, 99) == 0);
            a_req  = A_N'($urandom);
            a_data = (A_N*A_DW)'($urandom);
            b_req  = B_N'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            b_data = (B_N*B_DW)'($urandom);
            tick();
            exp_ga = m_wr[0] ? A_N'(1 << m_win[0]) : '0;
            exp_gb = m_wr[1] ? B_N'(1 << m_win[1]) : '0;
            n_cmp++;
            if ({a_gnt, a_cs, a_wn, a_wd, a_busy, a_last, a_addr} !==
                {exp_ga, m_wr[0], ~m_wr[0], m_wd[0], (m_wr[0] || m_hold[0] > 0), 3'(m_last[0]), 2'b00}) begin
                n_bad++;
                $display("FAIL rand_a cyc %0d: gnt=%b cs=%b wn=%b wd=%h busy=%b last=%0d, required %b %b %b %h %b %0d",
                         cyc, a_gnt, a_cs, a_wn, a_wd, a_busy, a_last,
                         exp_ga, m_wr[0], ~m_wr[0], m_wd[0], (m_wr[0] || m_hold[0] > 0), m_last[0]);
            end
            n_cmp++;
            if ({b_gnt, b_cs, b_wn, b_wd, b_busy, b_last, b_addr} !==
                {exp_gb, m_wr[1], ~m_wr[1], m_wd[1], (m_wr[1] || m_hold[1] > 0), 3'(m_last[1]), 2'b00}) begin
                n_bad++;
                $display("FAIL rand_b cyc %0d: gnt=%b cs=%b wn=%b wd=%h busy=%b last=%0d, required %b %b %b %h %b %0d",
                         cyc, b_gnt, b_cs, b_wn, b_wd, b_busy, b_last,
                         exp_gb, m_wr[1], ~m_wr[1], m_wd[1], (m_wr[1] || m_hold[1] > 0), m_last[1]);
            end
        end
        reset = 1'b0; a_req = '0; b_req = '0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_hold_zero();
        test_reset_mid();
        test_withdrawn();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
